// File: rtl/sdram_wb_prefetch.sv
// sdram_wb_prefetch: Wishbone front end for the SDRAM controller.
// Remaps the code/data windows onto SDRAM banks and keeps one aligned line
// of read data, filled critical-word-first, to serve sequential fetches.
module sdram_wb_prefetch #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wbs_stb_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic              ctrl_rw,
   output logic [31:0]       ctrl_data_in,
   output logic [3:0]        ctrl_mask,
   output logic              ctrl_in_valid,
   input  logic              ctrl_busy,
   input  logic              ctrl_out_valid,
   input  logic [31:0]       ctrl_data_out
);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OFF_W = IDX_W + 2;
   localparam int unsigned TAG_W = ADDR_W - OFF_W;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, PREFETCH, PF_WAIT, WR_REQ} state_e;

   state_e            state_q, state_d;
   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [3:0]        mask_q, mask_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              in_valid_q, in_valid_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [IDX_W-1:0]  pf_idx_q, pf_idx_d;
   logic              abort_q, abort_d;
   logic [31:0]       line_q [DEPTH];
   logic              line_we_c, wr_ack_c;

   logic              code_c, region_c, req_c, tag_hit_c, hit_c, inflight_c;
   logic              other_c, abort_c, accept_c, all_valid_c, unused_adr_c;
   logic [ADDR_W-1:0] mapped_c;
   logic [TAG_W-1:0]  tag_c;
   logic [IDX_W-1:0]  idx_c;

   // Request decode; a request is ignored in the cycle its ack is shown
   assign code_c      = (wbs_adr_i[31:24] == 8'h38);
   assign region_c    = code_c | (wbs_adr_i[31:24] == 8'h30);
   assign req_c       = wbs_stb_i & wbs_cyc_i & region_c & ~ack_q;
   // Code window folds banks 2/3 onto 0/1, data window folds 0/1 onto 2/3
   assign mapped_c    = {wbs_adr_i[ADDR_W-1:10], ~code_c, wbs_adr_i[8], wbs_adr_i[7:0]};
   assign tag_c       = mapped_c[ADDR_W-1:OFF_W];
   assign idx_c       = mapped_c[OFF_W-1:2];
   assign tag_hit_c   = (tag_c == tag_q);
   assign hit_c       = req_c & ~wbs_we_i & tag_hit_c & valid_q[idx_c];
   assign inflight_c  = req_c & ~wbs_we_i & tag_hit_c & ~valid_q[idx_c] & (idx_c == pf_idx_q);
   assign other_c     = req_c & ~hit_c & ~inflight_c;
   assign abort_c     = abort_q | other_c;
   assign accept_c    = in_valid_q & ~ctrl_busy;
   assign all_valid_c = &valid_q;
   assign unused_adr_c = ^wbs_adr_i;

   assign wbs_ack_o     = ack_q | wr_ack_c;
   assign wbs_dat_o     = dat_q;
   assign ctrl_addr     = addr_q;
   assign ctrl_rw       = rw_q;
   assign ctrl_data_in  = wdata_q;
   assign ctrl_mask     = mask_q;
   assign ctrl_in_valid = in_valid_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_c) state_d = wbs_we_i ? WR_REQ : (hit_c ? IDLE : RD_REQ);
         RD_REQ:   if (accept_c) state_d = RD_WAIT;
         RD_WAIT:  if (ctrl_out_valid) state_d = PREFETCH;
         PREFETCH: begin
            if (!in_valid_q) begin
               if (all_valid_c || abort_c) state_d = IDLE;
            end else if (accept_c) begin
               state_d = PF_WAIT;
            end
         end
         PF_WAIT:  if (ctrl_out_valid) state_d = abort_c ? IDLE : PREFETCH;
         WR_REQ:   if (accept_c) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      ack_d      = 1'b0;
      dat_d      = dat_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      mask_d     = mask_q;
      wdata_d    = wdata_q;
      in_valid_d = in_valid_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      pf_idx_d   = pf_idx_q;
      abort_d    = abort_q;
      line_we_c  = 1'b0;
      wr_ack_c   = 1'b0;
      case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (req_c) begin
               if (wbs_we_i) begin
                  in_valid_d = 1'b1;
                  rw_d       = 1'b1;
                  mask_d     = wbs_sel_i;
                  wdata_d    = wbs_dat_i;
                  addr_d     = mapped_c;
                  if (tag_hit_c) valid_d = '0;
               end else if (hit_c) begin
                  ack_d = 1'b1;
                  dat_d = line_q[idx_c];
               end else begin
                  valid_d    = '0;
                  tag_d      = tag_c;
                  pf_idx_d   = idx_c;
                  in_valid_d = 1'b1;
                  rw_d       = 1'b0;
                  mask_d     = 4'b0000;
                  addr_d     = mapped_c;
               end
            end
         end
         RD_REQ: if (accept_c) in_valid_d = 1'b0;
         RD_WAIT: begin
            if (ctrl_out_valid) begin
               line_we_c          = 1'b1;
               valid_d[pf_idx_q]  = 1'b1;
               ack_d              = 1'b1;
               dat_d              = ctrl_data_out;
               pf_idx_d           = pf_idx_q + IDX_W'(1);
            end
         end
         PREFETCH: begin
            abort_d = abort_c;
            if (hit_c) begin
               ack_d = 1'b1;
               dat_d = line_q[idx_c];
            end
            if (!in_valid_q) begin
               if (!all_valid_c && !abort_c) begin
                  in_valid_d = 1'b1;
                  rw_d       = 1'b0;
                  mask_d     = 4'b0000;
                  addr_d     = {tag_q, pf_idx_q, 2'b00};
               end
            end else if (accept_c) begin
               in_valid_d = 1'b0;
            end
         end
         PF_WAIT: begin
            abort_d = abort_c;
            if (hit_c) begin
               ack_d = 1'b1;
               dat_d = line_q[idx_c];
            end
            if (ctrl_out_valid) begin
               line_we_c         = 1'b1;
               valid_d[pf_idx_q] = 1'b1;
               pf_idx_d          = pf_idx_q + IDX_W'(1);
               if (inflight_c) begin
                  ack_d = 1'b1;
                  dat_d = ctrl_data_out;
               end
            end
         end
         WR_REQ: begin
            if (accept_c) begin
               wr_ack_c   = 1'b1;
               in_valid_d = 1'b0;
               rw_d       = 1'b0;
               mask_d     = 4'b0000;
            end
         end
         default: ;
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q      <= 1'b0;
         dat_q      <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         mask_q     <= '0;
         wdata_q    <= '0;
         in_valid_q <= 1'b0;
         valid_q    <= '0;
         tag_q      <= '0;
         pf_idx_q   <= '0;
         abort_q    <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         mask_q     <= mask_d;
         wdata_q    <= wdata_d;
         in_valid_q <= in_valid_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         pf_idx_q   <= pf_idx_d;
         abort_q    <= abort_d;
      end
   end

   // Line storage; contents are qualified by the valid bits
   always_ff @(posedge clk) begin
      if (line_we_c) line_q[pf_idx_q] <= ctrl_data_out;
   end

endmodule

// File: tb/tb_sdram_wb_prefetch.sv
// tb_sdram_wb_prefetch: scoreboard bench for sdram_wb_prefetch with a
// fixed-latency SDRAM controller model.
module tb_sdram_wb_prefetch;

   typedef struct packed {
      logic [22:0] addr;
      logic        rw;
      logic [3:0]  mask;
      logic [31:0] data;
   } req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        chk;
   } ack_t;

   logic        clk, rst_n;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [22:0] ctrl_addr;
   logic        ctrl_rw;
   logic [31:0] ctrl_data_in;
   logic [3:0]  ctrl_mask;
   logic        ctrl_in_valid;
   logic        ctrl_busy, ctrl_out_valid;
   logic [31:0] ctrl_data_out;

   int   checks = 0;
   int   errors = 0;
   int   n_acc  = 0;
   int   rsp_lat = 3;
   req_t exp_req[$];
   ack_t exp_ack[$];
   req_t mon_r;
   ack_t mon_a;

   sdram_wb_prefetch #(.DEPTH(8), .ADDR_W(23)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_data_in(ctrl_data_in),
      .ctrl_mask(ctrl_mask), .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
      .ctrl_out_valid(ctrl_out_valid), .ctrl_data_out(ctrl_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem(input logic [22:0] a);
      return {9'h15A, a};
   endfunction

   // Controller model: fixed latency read response per accepted read
   initial begin
      logic [22:0] ra;
      int          rl;
      ctrl_out_valid = 1'b0;
      ctrl_data_out  = '0;
      forever begin
         @(negedge clk);
         if (rst_n && ctrl_in_valid && !ctrl_busy && !ctrl_rw) begin
            ra = ctrl_addr;
            rl = rsp_lat;
            repeat (rl) @(posedge clk);
            #1;
            ctrl_out_valid = 1'b1;
            ctrl_data_out  = mem(ra);
            @(posedge clk);
            #1;
            ctrl_out_valid = 1'b0;
         end
      end
   end

   // Monitor: controller requests against the expected request queue
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && ctrl_in_valid && !ctrl_busy) begin
            n_acc++;
            checks++;
            if (exp_req.size() == 0) begin
               errors++;
               $display("FAIL ctrl_req unexpected addr=%h rw=%b mask=%b", ctrl_addr, ctrl_rw, ctrl_mask);
            end else begin
               mon_r = exp_req.pop_front();
               if (ctrl_addr !== mon_r.addr || ctrl_rw !== mon_r.rw || ctrl_mask !== mon_r.mask ||
                   (mon_r.rw && ctrl_data_in !== mon_r.data)) begin
                  errors++;
                  $display("FAIL ctrl_req got addr=%h rw=%b mask=%b data=%h expected addr=%h rw=%b mask=%b data=%h",
                           ctrl_addr, ctrl_rw, ctrl_mask, ctrl_data_in,
                           mon_r.addr, mon_r.rw, mon_r.mask, mon_r.data);
               end
            end
         end
      end
   end

   // Monitor: Wishbone acks against the expected ack queue
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && wbs_ack_o) begin
            checks++;
            if (exp_ack.size() == 0) begin
               errors++;
               $display("FAIL wb_ack unexpected dat=%h", wbs_dat_o);
            end else begin
               mon_a = exp_ack.pop_front();
               if (mon_a.chk && wbs_dat_o !== mon_a.data) begin
                  errors++;
                  $display("FAIL wb_ack_data got %h expected %h", wbs_dat_o, mon_a.data);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_req(input logic [22:0] a, input logic rw, input logic [3:0] m, input logic [31:0] d);
      req_t r;
      r.addr = a; r.rw = rw; r.mask = m; r.data = d;
      exp_req.push_back(r);
   endtask

   task automatic push_ack(input logic [31:0] d, input logic c);
      ack_t a;
      a.data = d; a.chk = c;
      exp_ack.push_back(a);
   endtask

   // Miss on mapped address a: critical word, ack, then the other 7 words in wrap order
   task automatic expect_read_miss(input logic [22:0] a);
      logic [2:0] ix;
      push_req(a, 1'b0, 4'b0000, 32'h0);
      push_ack(mem(a), 1'b1);
      ix = a[4:2];
      for (int i = 1; i < 8; i++) begin
         ix = ix + 3'd1;
         push_req({a[22:5], ix, 2'b00}, 1'b0, 4'b0000, 32'h0);
      end
   endtask

   // One Wishbone transaction; lat = cycles from strobe to the ack cycle
   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, output int lat);
      @(posedge clk);
      #1;
      wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      lat = 0;
      while (1) begin
         @(negedge clk);
         if (wbs_ack_o) break;
         lat++;
         if (lat > 100) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout adr=%h no ack after %0d cycles", adr, lat);
            break;
         end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while (exp_req.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ctrl_req_pending", 32'(exp_req.size()), 32'd0);
      repeat (12) @(negedge clk);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ack"},   32'(wbs_ack_o),     32'd0);
      chk({tag, "_dat"},   wbs_dat_o,          32'd0);
      chk({tag, "_ival"},  32'(ctrl_in_valid), 32'd0);
      chk({tag, "_rw"},    32'(ctrl_rw),       32'd0);
      chk({tag, "_mask"},  32'(ctrl_mask),     32'd0);
      chk({tag, "_addr"},  32'(ctrl_addr),     32'd0);
      chk({tag, "_wdata"}, ctrl_data_in,       32'd0);
   endtask

   initial begin
      int lat;
      int acc0;
      int bad;
      rst_n = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
      ctrl_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Cold miss with critical-word-first line fill
      expect_read_miss(23'h000010);
      wb_xfer(32'h3800_0010, 1'b0, 4'b0000, 32'h0, lat);
      chk("miss_lat", 32'(lat), 32'd5);
      wait_quiet();

      // Whole line now resident: every read is a one-cycle hit
      acc0 = n_acc;
      for (int i = 0; i < 8; i++) begin
         push_ack(mem(23'(i * 4)), 1'b1);
         wb_xfer(32'h3800_0000 + 32'(i * 4), 1'b0, 4'b0000, 32'h0, lat);
         chk("hit_lat", 32'(lat), 32'd1);
      end
      chk("hit_ctrl_reqs", 32'(n_acc - acc0), 32'd0);

      // Bank remap: data window 1->3, code window 3->1
      expect_read_miss(23'h000304);
      wb_xfer(32'h3000_0104, 1'b0, 4'b0000, 32'h0, lat);
      wait_quiet();
      expect_read_miss(23'h000104);
      wb_xfer(32'h3800_0304, 1'b0, 4'b0000, 32'h0, lat);
      wait_quiet();

      // Write during prefetch: in-flight read finishes, rest aborted, write issued
      push_req(23'h000000, 1'b0, 4'b0000, 32'h0);
      push_ack(mem(23'h000000), 1'b1);
      push_req(23'h000004, 1'b0, 4'b0000, 32'h0);
      push_req(23'h000008, 1'b1, 4'b0011, 32'hDEAD_BEEF);
      wb_xfer(32'h3800_0000, 1'b0, 4'b0000, 32'h0, lat);
      push_ack(32'h0, 1'b0);
      wb_xfer(32'h3800_0008, 1'b1, 4'b0011, 32'hDEAD_BEEF, lat);
      chk("wr_abort_lat", 32'(lat), 32'd5);
      wait_quiet();
      // The write invalidated the line: same word misses again
      expect_read_miss(23'h000008);
      wb_xfer(32'h3800_0008, 1'b0, 4'b0000, 32'h0, lat);
      chk("refetch_lat", 32'(lat), 32'd5);
      wait_quiet();

      // Write with controller busy for 5 cycles
      acc0 = n_acc;
      push_req(23'h000200, 1'b1, 4'b1111, 32'h1234_5678);
      push_ack(32'h0, 1'b0);
      @(posedge clk);
      #1 ctrl_busy = 1'b1;
      fork
         wb_xfer(32'h3000_0000, 1'b1, 4'b1111, 32'h1234_5678, lat);
         begin
            repeat (5) @(posedge clk);
            #1 ctrl_busy = 1'b0;
         end
      join
      chk("busy_wr_lat", 32'(lat), 32'd4);
      repeat (4) @(negedge clk);
      chk("busy_wr_reqs", 32'(n_acc - acc0), 32'd1);

      // Reset while waiting for read data; late response must be ignored
      rsp_lat = 8;
      push_req(23'h000040, 1'b0, 4'b0000, 32'h0);
      @(posedge clk);
      #1;
      wbs_adr_i = 32'h3800_0040; wbs_we_i = 1'b0; wbs_sel_i = 4'b0000;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      #1;
      chk_outputs_zero("async_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_lat = 3;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (wbs_ack_o) bad++;
      end
      chk("late_rsp_acks", 32'(bad), 32'd0);
      expect_read_miss(23'h000040);
      wb_xfer(32'h3800_0040, 1'b0, 4'b0000, 32'h0, lat);
      chk("post_rst_miss_lat", 32'(lat), 32'd5);
      wait_quiet();

      chk("ack_queue_left", 32'(exp_ack.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
